// File: rtl/dds_cfg_master.sv
// rtl/dds_cfg_master.sv - AXI-style burst master that programs and reads back the DDS register slave
module dds_cfg_master #(
    parameter logic [3:0]  MASTER_ID   = 4'h1,
    parameter logic [31:0] OFFSET_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        DDS_SLAVE_RSTN_SYNC,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_reg,
    input  logic [7:0]  cmd_len,
    input  logic [31:0] wr_data,
    input  logic        wr_data_valid,
    output logic        wr_data_ready,
    output logic [31:0] rd_data,
    output logic        rd_data_valid,
    output logic        rd_data_last,
    output logic        done,
    output logic [1:0]  done_resp,
    output logic [3:0]  M_WR_ADDR_ID,
    output logic [31:0] M_WR_ADDR_ADDR,
    output logic [7:0]  M_WR_ADDR_LEN,
    output logic [1:0]  M_WR_ADDR_BURST,
    output logic        M_WR_ADDR_VALID,
    input  logic        M_WR_ADDR_READY,
    output logic [31:0] M_WR_DATA,
    output logic [3:0]  M_WR_STRB,
    output logic        M_WR_DATA_LAST,
    output logic        M_WR_DATA_VALID,
    input  logic        M_WR_DATA_READY,
    input  logic [3:0]  M_WR_BACK_ID,
    input  logic [1:0]  M_WR_BACK_RESP,
    input  logic        M_WR_BACK_VALID,
    output logic        M_WR_BACK_READY,
    output logic [3:0]  M_RD_ADDR_ID,
    output logic [31:0] M_RD_ADDR_ADDR,
    output logic [7:0]  M_RD_ADDR_LEN,
    output logic [1:0]  M_RD_ADDR_BURST,
    output logic        M_RD_ADDR_VALID,
    input  logic        M_RD_ADDR_READY,
    input  logic [3:0]  M_RD_BACK_ID,
    input  logic [31:0] M_RD_DATA,
    input  logic [1:0]  M_RD_DATA_RESP,
    input  logic        M_RD_DATA_LAST,
    input  logic        M_RD_DATA_VALID,
    output logic        M_RD_DATA_READY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WA   = 3'd1,
        S_WD   = 3'd2,
        S_WB   = 3'd3,
        S_RA   = 3'd4,
        S_RD   = 3'd5,
        S_DONE = 3'd6
    } st_t;

    st_t        st_q, st_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] resp_q, resp_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] len_q, len_d;

    logic cmd_acc, w_hs, b_hs, r_hs, cnt_at_len;
    logic [1:0] r_resp_max;

    assign cmd_acc    = (st_q == S_IDLE) && cmd_valid;
    assign w_hs       = (st_q == S_WD) && wr_data_valid && M_WR_DATA_READY;
    assign b_hs       = (st_q == S_WB) && M_WR_BACK_VALID;
    assign r_hs       = (st_q == S_RD) && M_RD_DATA_VALID;
    assign cnt_at_len = (cnt_q == len_q);
    assign r_resp_max = (M_RD_DATA_RESP > resp_q) ? M_RD_DATA_RESP : resp_q;

    // State and datapath registers; the async reset abandons any burst in flight
    always_ff @(posedge clk or negedge DDS_SLAVE_RSTN_SYNC) begin
        if (!DDS_SLAVE_RSTN_SYNC) begin
            st_q   <= S_IDLE;
            cnt_q  <= 8'd0;
            resp_q <= 2'b00;
            reg_q  <= 8'd0;
            len_q  <= 8'd0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            resp_q <= resp_d;
            reg_q  <= reg_d;
            len_q  <= len_d;
        end
    end

    // Next-state: one address phase, then the data phase, then a single DONE cycle
    always_comb begin
        st_d = st_q;
        case (st_q)
            S_IDLE: if (cmd_acc) st_d = cmd_wr ? S_WA : S_RA;
            S_WA:   if (M_WR_ADDR_READY) st_d = S_WD;
            S_WD:   if (w_hs && cnt_at_len) st_d = S_WB;
            S_WB:   if (b_hs) st_d = S_DONE;
            S_RA:   if (M_RD_ADDR_READY) st_d = S_RD;
            S_RD:   if (r_hs && (M_RD_DATA_LAST || cnt_at_len)) st_d = S_DONE;
            S_DONE: st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    // Command latch, beat counter and worst-case response accumulator
    always_comb begin
        cnt_d  = cnt_q;
        resp_d = resp_q;
        reg_d  = reg_q;
        len_d  = len_q;
        if (cmd_acc) begin
            reg_d  = cmd_reg;
            len_d  = cmd_len;
            cnt_d  = 8'd0;
            resp_d = 2'b00;
        end
        if (((st_q == S_WA) && M_WR_ADDR_READY) || ((st_q == S_RA) && M_RD_ADDR_READY)) begin
            cnt_d = 8'd0;
        end
        if (w_hs) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (b_hs) begin
            resp_d = (M_WR_BACK_ID != MASTER_ID) ? 2'b10 : M_WR_BACK_RESP;
        end
        if (r_hs) begin
            cnt_d  = cnt_q + 8'd1;
            resp_d = r_resp_max;
            // A foreign ID or a LAST that disagrees with our own count is a slave error
            if ((M_RD_BACK_ID != MASTER_ID) || (M_RD_DATA_LAST != cnt_at_len)) begin
                resp_d = 2'b10;
            end
        end
    end

    // Bus outputs decoded from state; every valid/ready is gated by its own phase
    always_comb begin
        cmd_ready       = (st_q == S_IDLE) && DDS_SLAVE_RSTN_SYNC;
        M_WR_ADDR_ID    = MASTER_ID;
        M_WR_ADDR_ADDR  = OFFSET_ADDR + {24'b0, reg_q};
        M_WR_ADDR_LEN   = len_q;
        M_WR_ADDR_BURST = (reg_q[3:0] == 4'hA) ? 2'b00 : 2'b01;
        M_WR_ADDR_VALID = (st_q == S_WA);
        M_RD_ADDR_ID    = MASTER_ID;
        M_RD_ADDR_ADDR  = OFFSET_ADDR + {24'b0, reg_q};
        M_RD_ADDR_LEN   = len_q;
        M_RD_ADDR_BURST = (reg_q[3:0] == 4'hA) ? 2'b00 : 2'b01;
        M_RD_ADDR_VALID = (st_q == S_RA);
        M_WR_DATA       = (st_q == S_WD) ? wr_data : 32'd0;
        M_WR_STRB       = 4'hF;
        M_WR_DATA_LAST  = (st_q == S_WD) && cnt_at_len;
        M_WR_DATA_VALID = (st_q == S_WD) && wr_data_valid;
        wr_data_ready   = (st_q == S_WD) && M_WR_DATA_READY;
        M_WR_BACK_READY = (st_q == S_WB);
        M_RD_DATA_READY = (st_q == S_RD);
        rd_data         = M_RD_DATA;
        rd_data_valid   = (st_q == S_RD) && M_RD_DATA_VALID;
        rd_data_last    = r_hs && cnt_at_len;
        done            = (st_q == S_DONE);
        done_resp       = (st_q == S_DONE) ? resp_q : 2'b00;
    end

endmodule

// File: tb/tb_dds_cfg_master.sv
// tb/tb_dds_cfg_master.sv - table-driven bench for dds_cfg_master with a behavioural AXI slave
module tb_dds_cfg_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [7:0]  cmd_reg, cmd_len;
    logic [31:0] wr_data;
    logic        wr_data_valid, wr_data_ready;
    logic [31:0] rd_data;
    logic        rd_data_valid, rd_data_last, done;
    logic [1:0]  done_resp;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 clk = ~clk;

    dds_cfg_master dut (
        .clk(clk), .DDS_SLAVE_RSTN_SYNC(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_reg(cmd_reg), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last),
        .done(done), .done_resp(done_resp),
        .M_WR_ADDR_ID(awid), .M_WR_ADDR_ADDR(awaddr), .M_WR_ADDR_LEN(awlen),
        .M_WR_ADDR_BURST(awburst), .M_WR_ADDR_VALID(awvalid), .M_WR_ADDR_READY(awready),
        .M_WR_DATA(wdata), .M_WR_STRB(wstrb), .M_WR_DATA_LAST(wlast),
        .M_WR_DATA_VALID(wvalid), .M_WR_DATA_READY(wready),
        .M_WR_BACK_ID(bid), .M_WR_BACK_RESP(bresp), .M_WR_BACK_VALID(bvalid), .M_WR_BACK_READY(bready),
        .M_RD_ADDR_ID(arid), .M_RD_ADDR_ADDR(araddr), .M_RD_ADDR_LEN(arlen),
        .M_RD_ADDR_BURST(arburst), .M_RD_ADDR_VALID(arvalid), .M_RD_ADDR_READY(arready),
        .M_RD_BACK_ID(rid), .M_RD_DATA(rdata), .M_RD_DATA_RESP(rresp),
        .M_RD_DATA_LAST(rlast), .M_RD_DATA_VALID(rvalid), .M_RD_DATA_READY(rready)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  creg;
        logic [7:0]  len;
        logic        gaps;
        int          stall;
        logic [1:0]  sresp;
        logic        bad_id;
        int          last_at;
        logic [31:0] exp_addr;
        logic [1:0]  exp_burst;
        logic [1:0]  exp_resp;
        int          exp_beats;
        int          exp_lastcnt;
    } vec_t;

    vec_t vecs[11];

    int checks = 0;
    int failures = 0;

    // slave configuration, written by the main sequence only
    logic       cfg_gaps = 1'b0;
    int         cfg_aw_stall = 0;
    logic [1:0] cfg_sresp = 2'b00;
    logic       cfg_bad_id = 1'b0;
    int         cfg_last_at = 0;

    // slave state and monitor results, written by the slave process only
    int          stall_left = 0, r_beat = 0, src_beat = 0;
    logic        b_pend = 1'b0, r_active = 1'b0, aw_done = 1'b0, aw_seen = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [7:0]  prev_len = 8'd0;
    logic [31:0] a_addr = 32'd0;
    logic [7:0]  a_len = 8'd0;
    logic [1:0]  a_burst = 2'b00;
    logic [3:0]  a_id = 4'd0;
    int          w_cnt = 0, w_last_cnt = 0, w_last_idx = -1, w_err = 0, w_early = 0;
    int          aw_wait = 0, aw_unstable = 0, busy_rdy = 0;
    int          r_cnt = 0, r_last_cnt = 0, r_last_idx = -1, r_err = 0;
    int          done_cnt = 0;
    logic [1:0]  done_resp_cap = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural slave and write-data source: drive at negedge, observe handshakes 1ns later
    initial begin
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rlast = 0; rresp = 0; rid = 0;
        wr_data_valid = 0; wr_data = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall_left = 0; b_pend = 0; r_active = 0; r_beat = 0; src_beat = 0;
                aw_done = 0; aw_seen = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
                wr_data_valid = 0;
            end else begin
                awready = (stall_left == 0);
                arready = 1'b1;
                wready  = 1'b1;
                bvalid  = b_pend;
                bid     = cfg_bad_id ? 4'h6 : 4'h1;
                bresp   = cfg_sresp;
                rvalid  = r_active && (!cfg_gaps || ($urandom_range(0, 2) != 0));
                rdata   = 32'hD000_0000 + 32'(r_beat);
                rlast   = (r_beat == cfg_last_at);
                rresp   = (r_beat == 0) ? cfg_sresp : 2'b00;
                rid     = cfg_bad_id ? 4'h7 : 4'h1;
                wr_data_valid = !cfg_gaps || ($urandom_range(0, 2) != 0);
                wr_data = 32'h0000_1000 + 32'(src_beat);
            end
            #1;
            if (rstn) begin
                if (cmd_valid && cmd_ready) begin
                    w_cnt = 0; w_last_cnt = 0; w_last_idx = -1; w_err = 0; w_early = 0;
                    aw_wait = 0; aw_unstable = 0; busy_rdy = 0; aw_done = 0; aw_seen = 0;
                    r_cnt = 0; r_last_cnt = 0; r_last_idx = -1; r_err = 0;
                    done_cnt = 0; src_beat = 0; stall_left = cfg_aw_stall;
                end
                if (awvalid) begin
                    if (aw_seen && (awaddr !== prev_addr || awlen !== prev_len)) aw_unstable++;
                    if (cmd_ready) busy_rdy++;
                    prev_addr = awaddr; prev_len = awlen; aw_seen = 1;
                    if (awready) begin
                        a_addr = awaddr; a_len = awlen; a_burst = awburst; a_id = awid;
                        aw_done = 1; aw_seen = 0;
                    end else begin
                        aw_wait++;
                        if (stall_left > 0) stall_left--;
                    end
                end
                if (wvalid && !aw_done) w_early++;
                if (wvalid && wready) begin
                    if (wstrb !== 4'hF || wdata !== 32'h0000_1000 + 32'(src_beat) || !wr_data_ready) w_err++;
                    if (wlast) begin
                        w_last_cnt++; w_last_idx = src_beat; b_pend = 1;
                    end
                    w_cnt++; src_beat++;
                end
                if (bvalid && bready) b_pend = 0;
                if (arvalid && arready) begin
                    a_addr = araddr; a_len = arlen; a_burst = arburst; a_id = arid;
                    r_active = 1; r_beat = 0;
                end
                if (rvalid && rready) begin
                    if (!rd_data_valid || rd_data !== 32'hD000_0000 + 32'(r_beat)) r_err++;
                    if (rd_data_last) begin
                        r_last_cnt++; r_last_idx = r_beat;
                    end
                    r_cnt++;
                    if (rlast) r_active = 0;
                    r_beat++;
                end else if (rd_data_valid || rd_data_last) begin
                    r_err++;
                end
                if (done) begin
                    done_cnt++; done_resp_cap = done_resp; r_active = 0;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [7:0] creg, input logic [7:0] len, input string tag);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_reg = creg; cmd_len = len;
        #2;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk); #2; t++;
        end
        if (t >= 50) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 2000) begin
            @(negedge clk); #2; t++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        cfg_gaps = v.gaps; cfg_aw_stall = v.stall; cfg_sresp = v.sresp;
        cfg_bad_id = v.bad_id; cfg_last_at = v.last_at;
        issue(v.wr, v.creg, v.len, tag);
        wait_done(tag);
        chk({tag, "_addr"}, a_addr, v.exp_addr);
        chk({tag, "_len"}, 32'(a_len), 32'(v.len));
        chk({tag, "_burst"}, 32'(a_burst), 32'(v.exp_burst));
        chk({tag, "_id"}, 32'(a_id), 32'h1);
        chk({tag, "_resp"}, 32'(done_resp_cap), 32'(v.exp_resp));
        if (v.wr) begin
            chk({tag, "_w_beats"}, 32'(w_cnt), 32'(v.exp_beats));
            chk({tag, "_w_last_cnt"}, 32'(w_last_cnt), 32'd1);
            chk({tag, "_w_last_idx"}, 32'(w_last_idx), 32'(v.len));
            chk({tag, "_w_data_err"}, 32'(w_err), 32'd0);
            chk({tag, "_w_before_aw"}, 32'(w_early), 32'd0);
            chk({tag, "_aw_wait"}, 32'(aw_wait), 32'(v.stall));
            chk({tag, "_aw_unstable"}, 32'(aw_unstable), 32'd0);
            chk({tag, "_cmd_ready_busy"}, 32'(busy_rdy), 32'd0);
        end else begin
            chk({tag, "_r_beats"}, 32'(r_cnt), 32'(v.exp_beats));
            chk({tag, "_r_last_cnt"}, 32'(r_last_cnt), 32'(v.exp_lastcnt));
            if (v.exp_lastcnt == 1) chk({tag, "_r_last_idx"}, 32'(r_last_idx), 32'(v.len));
            chk({tag, "_r_data_err"}, 32'(r_err), 32'd0);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_awvalid"}, 32'(awvalid), 32'd0);
        chk({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        chk({tag, "_wlast"}, 32'(wlast), 32'd0);
        chk({tag, "_wr_data_ready"}, 32'(wr_data_ready), 32'd0);
        chk({tag, "_bready"}, 32'(bready), 32'd0);
        chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(rready), 32'd0);
        chk({tag, "_rd_data_valid"}, 32'(rd_data_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    endtask

    initial begin
        int t;
        //            wr    reg    len    gap stall sresp bad last  exp_addr        burst  resp  beats lastcnt
        vecs[0]  = '{1'b1, 8'h11, 8'd0,   1'b0, 0, 2'b00, 1'b0, 0,   32'h4000_0011, 2'b01, 2'b00, 1,   1};
        vecs[1]  = '{1'b1, 8'h0A, 8'd255, 1'b1, 0, 2'b00, 1'b0, 255, 32'h4000_000A, 2'b00, 2'b00, 256, 1};
        vecs[2]  = '{1'b0, 8'h01, 8'd3,   1'b0, 0, 2'b00, 1'b0, 3,   32'h4000_0001, 2'b01, 2'b00, 4,   1};
        vecs[3]  = '{1'b0, 8'h20, 8'd0,   1'b0, 0, 2'b10, 1'b0, 0,   32'h4000_0020, 2'b01, 2'b10, 1,   1};
        vecs[4]  = '{1'b1, 8'h1B, 8'd1,   1'b0, 0, 2'b10, 1'b0, 1,   32'h4000_001B, 2'b01, 2'b10, 2,   1};
        vecs[5]  = '{1'b1, 8'h05, 8'd7,   1'b0, 5, 2'b00, 1'b0, 7,   32'h4000_0005, 2'b01, 2'b00, 8,   1};
        vecs[6]  = '{1'b0, 8'h3A, 8'd2,   1'b1, 0, 2'b00, 1'b1, 2,   32'h4000_003A, 2'b00, 2'b10, 3,   1};
        vecs[7]  = '{1'b1, 8'h22, 8'd0,   1'b0, 0, 2'b00, 1'b1, 0,   32'h4000_0022, 2'b01, 2'b10, 1,   1};
        vecs[8]  = '{1'b0, 8'h02, 8'd3,   1'b0, 0, 2'b00, 1'b0, 1,   32'h4000_0002, 2'b01, 2'b10, 2,   0};
        vecs[9]  = '{1'b0, 8'h03, 8'd1,   1'b0, 0, 2'b00, 1'b0, 5,   32'h4000_0003, 2'b01, 2'b10, 2,   1};
        vecs[10] = '{1'b0, 8'h04, 8'd2,   1'b0, 0, 2'b01, 1'b0, 2,   32'h4000_0004, 2'b01, 2'b01, 3,   1};

        cmd_valid = 0; cmd_wr = 0; cmd_reg = 0; cmd_len = 0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk_quiet("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #2;
        chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // reset in the middle of a write burst, after three beats have gone out
        cfg_gaps = 0; cfg_aw_stall = 0; cfg_sresp = 2'b00; cfg_bad_id = 0; cfg_last_at = 7;
        issue(1'b1, 8'h07, 8'd7, "mid");
        t = 0;
        while (w_cnt < 3 && t < 100) begin
            @(negedge clk); #2; t++;
        end
        chk("mid_reach_beat3", 32'(w_cnt >= 3), 32'd1);
        @(posedge clk);
        #1;
        chk("mid_wvalid_before_reset", 32'(wvalid), 32'd1);
        rstn = 1'b0;
        #1;
        chk_quiet("mid_reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #2;
        chk("mid_release_cmd_ready", 32'(cmd_ready), 32'd1);
        run_vec('{1'b1, 8'h12, 8'd2, 1'b0, 0, 2'b00, 1'b0, 2, 32'h4000_0012, 2'b01, 2'b00, 3, 1}, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
